serial_add_sequencer: RTL

// - Adds two WIDTH-bit operands one bit at a time, LSB first, through a single external
//   1-bit full-adder cell (a, b, cin -> sum, cout).
// - Sequences that cell: keeps the operand shift registers and the carry flop, and

---
 rtl/serial_add_sequencer.sv | 119 +++++++++++
 1 files changed

// File: rtl/serial_add_sequencer.sv
// Bit-serial adder sequencer: drives an external 1-bit full-adder cell LSB first
// and assembles the WIDTH-bit sum behind a start/ready/done handshake.
module serial_add_sequencer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             cin,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             fa_a,
   output logic             fa_b,
   output logic             fa_cin,
   input  logic             fa_sum,
   input  logic             fa_cout
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] work;
   logic             carry;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] result_r;
   logic             cout_r;
   logic             last_bit;

   assign last_bit = (cnt == CNT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // abort takes priority over completion, so a cancelled sum never reaches DONE
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (start) state_nxt = S_RUN;
         S_RUN: begin
            if (abort) begin
               state_nxt = S_IDLE;
            end else if (last_bit) begin
               state_nxt = S_DONE;
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sr     <= '0;
         b_sr     <= '0;
         work     <= '0;
         carry    <= 1'b0;
         cnt      <= '0;
         result_r <= '0;
         cout_r   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  a_sr  <= op_a;
                  b_sr  <= op_b;
                  carry <= cin;
                  cnt   <= '0;
               end
            end
            S_RUN: begin
               if (!abort) begin
                  a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
                  b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
                  work  <= {fa_sum, work[WIDTH-1:1]};
                  carry <= fa_cout;
                  cnt   <= cnt + CNT_W'(1);
                  // the final sum bit is still on fa_sum, so assemble the word directly
                  if (last_bit) begin
                     result_r <= {fa_sum, work[WIDTH-1:1]};
                     cout_r   <= fa_cout;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign ready  = (state == S_IDLE);
   assign busy   = (state == S_RUN);
   assign done   = (state == S_DONE);
   assign result = result_r;
   assign cout   = cout_r;
   assign fa_a   = busy & a_sr[0];
   assign fa_b   = busy & b_sr[0];
   assign fa_cin = busy & carry;

endmodule
